// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;
  localparam int CNT_W        = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's complement: passes the magnitude through or negates it.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] mag_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~mag_i + {{(W-1){1'b0}}, 1'b1}) : mag_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: 33-cycle fixed latency,
// shift-add multiply and restoring divide sharing one 64-bit accumulator.
//
// state | meaning
// IDLE  | waiting for start_i; stall_o follows start_i
// BUSY  | one multiply/divide iteration per cycle, 32 in total
// DONE  | done_o strobe, registered result valid; always back to IDLE
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  import muldiv_pkg::*;

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       funct3_q;
  logic [31:0]      rs1_q, rs2_q, opb_q;
  logic [4:0]       rd_q, rd_out_q;
  logic [63:0]      acc_q, acc_d;
  logic             q_neg_q, r_neg_q;
  logic [31:0]      result_q, result_d;

  logic        accept, last_iter, is_div;
  logic        a_signed, b_signed, a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [32:0] add_a, add_b, add_s;
  logic [31:0] qp_mag, qp_val, rem_val;
  logic        div_by_zero, div_ovf;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE:    stall_o = start_i;
      BUSY:    stall_o = 1'b1;
      DONE:    done_o  = ~flush_i;
      default: ;
    endcase
  end

  assign accept    = (state_q == IDLE) & start_i & ~flush_i;
  assign last_iter = (state_q == BUSY) & (cnt_q == LAST_CNT);

  // ---------------- operand conditioning ----------------
  assign a_signed = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign b_signed = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
  assign a_neg    = a_signed & rs1_data_i[31];
  assign b_neg    = b_signed & rs2_data_i[31];

  muldiv_sign_fix #(.W(32)) u_fix_a (.mag_i(rs1_data_i), .neg_i(a_neg), .val_o(abs_a));
  muldiv_sign_fix #(.W(32)) u_fix_b (.mag_i(rs2_data_i), .neg_i(b_neg), .val_o(abs_b));

  // ---------------- iteration datapath ----------------
  // The 33-bit adder adds the multiplicand or subtracts the divisor.
  assign is_div = f3_is_div(funct3_q);
  assign add_a  = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
  assign add_b  = is_div ? ~{1'b0, opb_q} : {1'b0, opb_q};
  assign add_s  = add_a + add_b + {32'b0, is_div};

  always_comb begin
    if (is_div) begin
      acc_d = add_s[32] ? {acc_q[62:0], 1'b0} : {add_s[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = acc_q[0] ? {add_s, acc_q[31:1]} : {1'b0, acc_q[63:32], acc_q[31:1]};
    end
  end

  // ---------------- result formation ----------------
  // Negating a 64-bit product: high word is ~hi, plus one only when lo == 0.
  assign qp_mag = is_div ? acc_d[31:0]
                         : acc_d[63:32] + {31'b0, q_neg_q & (|acc_d[31:0])};

  muldiv_sign_fix #(.W(32)) u_fix_qp  (.mag_i(qp_mag),       .neg_i(q_neg_q), .val_o(qp_val));
  muldiv_sign_fix #(.W(32)) u_fix_rem (.mag_i(acc_d[63:32]), .neg_i(r_neg_q), .val_o(rem_val));

  assign div_by_zero = (rs2_q == 32'h0);
  assign div_ovf     = ((funct3_q == F3_DIV) | (funct3_q == F3_REM)) &
                       (rs1_q == 32'h8000_0000) & (rs2_q == 32'hFFFF_FFFF);

  always_comb begin
    result_d = 32'h0;
    case (funct3_q)
      F3_MUL:                      result_d = acc_d[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_d = qp_val;
      F3_DIV, F3_DIVU: begin
        if (div_by_zero)  result_d = 32'hFFFF_FFFF;
        else if (div_ovf) result_d = 32'h8000_0000;
        else              result_d = qp_val;
      end
      default: begin
        if (div_by_zero)  result_d = rs1_q;
        else if (div_ovf) result_d = 32'h0;
        else              result_d = rem_val;
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      funct3_q <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opb_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      acc_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        funct3_q <= funct3_i;
        rs1_q    <= rs1_data_i;
        rs2_q    <= rs2_data_i;
        rd_q     <= rd_i;
        cnt_q    <= '0;
        q_neg_q  <= a_neg ^ b_neg;
        r_neg_q  <= a_neg;
        if (f3_is_div(funct3_i)) begin
          acc_q <= {32'h0, abs_a};
          opb_q <= abs_b;
        end else begin
          acc_q <= {32'h0, abs_b};
          opb_q <= abs_a;
        end
      end else if (state_q == BUSY) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (last_iter && !flush_i) begin
        result_q <= result_d;
        rd_out_q <= rd_q;
      end
    end
  end

  assign result_o = result_q;
  assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M corner cases, kill
// scenarios and random ops compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic [4:0]  rd_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res = 32'h0;
  logic [4:0]  last_rd  = 5'h0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .funct3_i(funct3_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", tag, got, want);
    end
  endtask

  // Reference: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_muldiv(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r  = 32'h0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Entered just after an edge (cycle 0); returns just after the edge of cycle 34
  // with start_i still high, as the pipeline would present it.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int done_cyc, done_cnt, stall_bad;
    logic [31:0] want;
    want = ref_muldiv(f3, a, b);
    start_i = 1'b1; funct3_i = f3; rs1_data_i = a; rs2_data_i = b; rd_i = rd;
    #1;
    check("stall_accept", 32'(stall_o), 32'd1);
    done_cyc = -1; done_cnt = 0; stall_bad = 0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) begin
        rs1_data_i = $urandom; rs2_data_i = $urandom; rd_i = 5'($urandom);
      end
      if (done_o) begin done_cnt++; done_cyc = c; end
      if (stall_o !== (c <= 32)) stall_bad++;
    end
    check("done_cycle", 32'(done_cyc), 32'd33);
    check("done_count", 32'(done_cnt), 32'd1);
    check("stall_window", 32'(stall_bad), 32'd0);
    check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, want);
    check("rd", 32'(rd_o), 32'(rd));
    last_res = want;
    last_rd  = rd;
    @(posedge clk_i); #1;
  endtask

  task automatic idle_gap();
    start_i = 1'b0;
    #1;
    check("gap_stall", 32'(stall_o), 32'd0);
    check("gap_done", 32'(done_o), 32'd0);
    check("hold_result", result_o, last_res);
    check("hold_rd", 32'(rd_o), 32'(last_rd));
    @(posedge clk_i); #1;
  endtask

  task automatic kill_op(input logic use_reset);
    int dcnt;
    start_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_i = 5'd9;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_i); #1;
    end
    check("kill_busy_stall", 32'(stall_o), 32'd1);
    start_i = 1'b0;
    if (use_reset) rst_i = 1'b0;
    else flush_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b1; flush_i = 1'b0;
    #1;
    check("kill_stall", 32'(stall_o), 32'd0);
    check("kill_done", 32'(done_o), 32'd0);
    if (use_reset) begin
      last_res = 32'h0;
      last_rd  = 5'h0;
    end
    check("kill_result", result_o, last_res);
    check("kill_rd", 32'(rd_o), 32'(last_rd));
    dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #1;
      if (done_o) dcnt++;
    end
    check("kill_no_done", 32'(dcnt), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int sc;
    rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    funct3_i = 3'd0; rs1_data_i = 32'h0; rs2_data_i = 32'h0; rd_i = 5'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", result_o, 32'h0);
    check("rst_rd", 32'(rd_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // back-to-back: second accept at cycle 34, done at 67
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6);
    idle_gap();
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);  idle_gap();
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8);          idle_gap();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);         idle_gap();
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);         idle_gap();
    run_op(3'd5, 32'd100, 32'd7, 5'd12);               idle_gap();
    run_op(3'd7, 32'd100, 32'd7, 5'd13);               idle_gap();
    run_op(3'd4, 32'h1234, 32'd0, 5'd14);              idle_gap();
    run_op(3'd6, 32'h1234, 32'd0, 5'd15);              idle_gap();
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16); idle_gap();
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17); idle_gap();

    kill_op(1'b0);
    kill_op(1'b1);

    // flush together with start: no accept
    start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd3; rs2_data_i = 32'd3;
    @(posedge clk_i); #1;
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    sc = 0;
    for (int c = 0; c < 36; c++) begin
      if (stall_o || done_o) sc++;
      @(posedge clk_i); #1;
    end
    check("flush_accept_quiet", 32'(sc), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom));
      if ($urandom_range(0, 1) == 1) idle_gap();
    end
    idle_gap();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
